// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Arbitrates the single register-file write port between the in-order
//   pipeline writeback and a multi-cycle unit (MDU). Pipeline writes always
//   win. MDU results are queued in a small FIFO and drained whenever the
//   pipeline leaves the write port free. A 32-bit scoreboard tracks which
//   registers still await a multi-cycle result.
//
//   Optional feature: define REGWR_BYPASS_EN to let an MDU result go straight
//   to the register file when the buffer is empty and the pipeline is idle.
//   Without the macro every MDU result is buffered first.
//
// Parameters
//   FIFO_DEPTH  result buffer entries (power of two, 2..16)
// Ports
//   clk                            clock, rising edge
//   rst                            asynchronous reset, active-low
//   pipe_we/pipe_addr/pipe_data    pipeline writeback request
//   mdu_valid/mdu_addr/mdu_data    MDU result offer
//   mdu_ready                      buffer can accept an offer this cycle
//   iss_valid/iss_addr             MDU op issued, destination becomes pending
//   WriteEn/WriteAddr/WriteData    register-file write port (combinational)
//   pending                        per-register awaiting-result flags
//   fifo_count                     buffer occupancy
module reg_write_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_addr,
  input  logic [31:0] pipe_data,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_addr,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_addr,
  output logic        WriteEn,
  output logic [4:0]  WriteAddr,
  output logic [31:0] WriteData,
  output logic [31:0] pending,
  output logic [4:0]  fifo_count
);

  localparam int         PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] DEPTH_CNT = 5'(FIFO_DEPTH);

  logic [4:0]       bufAddr [FIFO_DEPTH];
  logic [31:0]      bufData [FIFO_DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [4:0]       count;
  logic [31:0]      pendingQ;

  logic             pipeReq;
  logic             bypassHit;
  logic             doPush;
  logic             doPop;
  logic [31:0]      setMask;
  logic [31:0]      clrMask;

  // A pipeline write to R0 is not a request, so the buffer may drain.
  assign pipeReq   = pipe_we && (pipe_addr != 5'd0);
  // Readiness looks only at occupancy: a full buffer refuses even while popping.
  assign mdu_ready = (count < DEPTH_CNT);
  assign doPop     = !pipeReq && (count != 5'd0);

`ifdef REGWR_BYPASS_EN
  assign bypassHit = mdu_valid && (mdu_addr != 5'd0) && (count == 5'd0) && !pipeReq;
`else
  assign bypassHit = 1'b0;
`endif

  // Accepted offers to R0 are consumed but never stored.
  assign doPush = mdu_valid && mdu_ready && (mdu_addr != 5'd0) && !bypassHit;

  always_comb begin
    WriteEn   = 1'b0;
    WriteAddr = 5'd0;
    WriteData = 32'd0;
    if (pipeReq) begin
      WriteEn   = 1'b1;
      WriteAddr = pipe_addr;
      WriteData = pipe_data;
    end else if (doPop) begin
      WriteEn   = 1'b1;
      WriteAddr = bufAddr[rdPtr];
      WriteData = bufData[rdPtr];
    end else if (bypassHit) begin
      WriteEn   = 1'b1;
      WriteAddr = mdu_addr;
      WriteData = mdu_data;
    end
  end

  // Only MDU-sourced writes retire a pending flag; a same-cycle issue re-sets it.
  always_comb begin
    clrMask = 32'd0;
    setMask = 32'd0;
    if (doPop) begin
      clrMask[bufAddr[rdPtr]] = 1'b1;
    end else if (bypassHit) begin
      clrMask[mdu_addr] = 1'b1;
    end
    if (iss_valid && (iss_addr != 5'd0)) begin
      setMask[iss_addr] = 1'b1;
    end
  end

  // Registered control state: pointers, occupancy, scoreboard.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= 5'd0;
      pendingQ <= 32'd0;
    end else begin
      if (doPop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      if (doPush) begin
        wrPtr <= wrPtr + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
      pendingQ <= ((pendingQ & ~clrMask) | setMask) & 32'hFFFF_FFFE;
    end
  end

  // Buffer storage; contents are meaningless outside the valid window.
  always_ff @(posedge clk) begin
    if (doPush) begin
      bufAddr[wrPtr] <= mdu_addr;
      bufData[wrPtr] <= mdu_data;
    end
  end

  assign pending    = pendingQ;
  assign fifo_count = count;

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

  localparam int DEPTH = 4;
`ifdef REGWR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        mdu_valid;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        WriteEn;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;
  logic [31:0] pending;
  logic [4:0]  fifo_count;

  int errors = 0;
  int checks = 0;

  reg_write_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .WriteEn(WriteEn), .WriteAddr(WriteAddr), .WriteData(WriteData),
    .pending(pending), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of outstanding results and a pending bitmap.
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;
  ent_t        q[$];
  logic [31:0] pend;

  typedef struct {
    bit          pwe;  logic [4:0] pa;  logic [31:0] pd;
    bit          mv;   logic [4:0] ma;  logic [31:0] md;
    bit          iv;   logic [4:0] ia;
    bit          eWe;  logic [4:0] eA;  logic [31:0] eD;
    bit          eRdy; logic [4:0] eCnt; logic [31:0] ePend;
  } vec_t;
  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic setIdle();
    pipe_we = 1'b0; pipe_addr = 5'd0; pipe_data = 32'd0;
    mdu_valid = 1'b0; mdu_addr = 5'd0; mdu_data = 32'd0;
    iss_valid = 1'b0; iss_addr = 5'd0;
  endtask

  task automatic modelCheck();
    bit          pr;
    bit          eWe;
    logic [4:0]  eA;
    logic [31:0] eD;
    pr  = pipe_we && (pipe_addr != 5'd0);
    eWe = 1'b0; eA = 5'd0; eD = 32'd0;
    if (pr) begin
      eWe = 1'b1; eA = pipe_addr; eD = pipe_data;
    end else if (q.size() > 0) begin
      eWe = 1'b1; eA = q[0].a; eD = q[0].d;
    end else if (BYP && mdu_valid && (mdu_addr != 5'd0)) begin
      eWe = 1'b1; eA = mdu_addr; eD = mdu_data;
    end
    chk("model_WriteEn", 32'(WriteEn), 32'(eWe));
    if (eWe) begin
      chk("model_WriteAddr", 32'(WriteAddr), 32'(eA));
      chk("model_WriteData", WriteData, eD);
    end
    chk("model_mdu_ready", 32'(mdu_ready), 32'(q.size() < DEPTH));
    chk("model_fifo_count", 32'(fifo_count), 32'(q.size()));
    chk("model_pending", pending, pend);
  endtask

  task automatic modelUpdate();
    bit   pr;
    bit   byp;
    bit   rdy;
    ent_t e;
    pr  = pipe_we && (pipe_addr != 5'd0);
    rdy = (q.size() < DEPTH);
    byp = BYP && mdu_valid && (mdu_addr != 5'd0) && (q.size() == 0) && !pr;
    if (!pr && q.size() > 0) begin
      e = q.pop_front();
      pend[e.a] = 1'b0;
    end else if (byp) begin
      pend[mdu_addr] = 1'b0;
    end
    if (mdu_valid && rdy && (mdu_addr != 5'd0) && !byp) begin
      e.a = mdu_addr; e.d = mdu_data;
      q.push_back(e);
    end
    if (iss_valid && (iss_addr != 5'd0)) pend[iss_addr] = 1'b1;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    #1;
    modelCheck();
    modelUpdate();
    @(negedge clk);
  endtask

  initial begin
    // Hand-derived vectors for the default (buffered) build.
    tbl[0]  = '{0,0,0,            0,0,0,                 1,5, 0,0,0,               1,0,0};
    tbl[1]  = '{0,0,0,            1,5,32'hDEADBEEF,      0,0, 0,0,0,               1,0,32'h20};
    tbl[2]  = '{0,0,0,            0,0,0,                 0,0, 1,5,32'hDEADBEEF,    1,1,32'h20};
    tbl[3]  = '{0,0,0,            0,0,0,                 0,0, 0,0,0,               1,0,0};
    tbl[4]  = '{1,1,32'h11,       1,2,32'hA2,            0,0, 1,1,32'h11,          1,0,0};
    tbl[5]  = '{1,2,32'h12,       1,3,32'hA3,            0,0, 1,2,32'h12,          1,1,0};
    tbl[6]  = '{1,3,32'h13,       1,4,32'hA4,            0,0, 1,3,32'h13,          1,2,0};
    tbl[7]  = '{1,4,32'h14,       1,6,32'hA6,            0,0, 1,4,32'h14,          1,3,0};
    tbl[8]  = '{1,1,32'h15,       0,0,0,                 0,0, 1,1,32'h15,          0,4,0};
    tbl[9]  = '{0,0,0,            1,9,32'h99,            0,0, 1,2,32'hA2,          0,4,0};
    tbl[10] = '{0,0,0,            1,9,32'h99,            0,0, 1,3,32'hA3,          1,3,0};
    tbl[11] = '{0,0,0,            0,0,0,                 0,0, 1,4,32'hA4,          1,3,0};
    tbl[12] = '{0,0,0,            0,0,0,                 0,0, 1,6,32'hA6,          1,2,0};
    tbl[13] = '{0,0,0,            0,0,0,                 0,0, 1,9,32'h99,          1,1,0};
    tbl[14] = '{0,0,0,            0,0,0,                 0,0, 0,0,0,               1,0,0};
    tbl[15] = '{0,0,0,            1,7,32'h77,            1,7, 0,0,0,               1,0,0};
    tbl[16] = '{1,0,32'hBAD,      1,0,32'hBAD,           1,7, 1,7,32'h77,          1,1,32'h80};
    tbl[17] = '{0,0,0,            0,0,0,                 0,0, 0,0,0,               1,0,32'h80};
    tbl[18] = '{1,0,32'h5A5A,     1,0,32'h1234,          0,0, 0,0,0,               1,0,32'h80};
    tbl[19] = '{0,0,0,            0,0,0,                 0,0, 0,0,0,               1,0,32'h80};

    q.delete();
    pend = 32'd0;

    // Reset state, including pipeline pass-through while reset is held.
    rst = 1'b0;
    setIdle();
    pipe_we = 1'b1; pipe_addr = 5'd3; pipe_data = 32'hCAFE;
    #2;
    chk("rst_WriteEn_pipe", 32'(WriteEn), 32'd1);
    chk("rst_WriteAddr_pipe", 32'(WriteAddr), 32'd3);
    chk("rst_WriteData_pipe", WriteData, 32'hCAFE);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_pending", pending, 32'd0);
    chk("rst_mdu_ready", 32'(mdu_ready), 32'd1);
    setIdle();
    #1;
    chk("rst_WriteEn_idle", 32'(WriteEn), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

`ifndef REGWR_BYPASS_EN
    for (int i = 0; i < 20; i++) begin
      pipe_we = tbl[i].pwe; pipe_addr = tbl[i].pa; pipe_data = tbl[i].pd;
      mdu_valid = tbl[i].mv; mdu_addr = tbl[i].ma; mdu_data = tbl[i].md;
      iss_valid = tbl[i].iv; iss_addr = tbl[i].ia;
      #1;
      chk($sformatf("row%0d_WriteEn", i), 32'(WriteEn), 32'(tbl[i].eWe));
      if (tbl[i].eWe) begin
        chk($sformatf("row%0d_WriteAddr", i), 32'(WriteAddr), 32'(tbl[i].eA));
        chk($sformatf("row%0d_WriteData", i), WriteData, tbl[i].eD);
      end
      chk($sformatf("row%0d_mdu_ready", i), 32'(mdu_ready), 32'(tbl[i].eRdy));
      chk($sformatf("row%0d_fifo_count", i), 32'(fifo_count), 32'(tbl[i].eCnt));
      chk($sformatf("row%0d_pending", i), pending, tbl[i].ePend);
      tick();
    end
`else
    // Bypass: result lands in the same cycle it is offered.
    setIdle();
    iss_valid = 1'b1; iss_addr = 5'd5;
    tick();
    setIdle();
    mdu_valid = 1'b1; mdu_addr = 5'd5; mdu_data = 32'hDEADBEEF;
    #1;
    chk("byp_WriteEn", 32'(WriteEn), 32'd1);
    chk("byp_WriteAddr", 32'(WriteAddr), 32'd5);
    chk("byp_WriteData", WriteData, 32'hDEADBEEF);
    chk("byp_mdu_ready", 32'(mdu_ready), 32'd1);
    tick();
    setIdle();
    #1;
    chk("byp_pending5", 32'(pending[5]), 32'd0);
    chk("byp_fifo_count", 32'(fifo_count), 32'd0);
    tick();
`endif

    // Reset asserted while draining a three-entry buffer.
    for (int i = 0; i < 3; i++) begin
      pipe_we = 1'b1; pipe_addr = 5'(10 + i); pipe_data = $urandom;
      mdu_valid = 1'b1; mdu_addr = 5'(20 + i); mdu_data = 32'hC0DE0000 + 32'(i);
      iss_valid = 1'b1; iss_addr = 5'(20 + i);
      tick();
    end
    setIdle();
    #1;
    chk("drain_fifo_count", 32'(fifo_count), 32'd3);
    chk("drain_WriteAddr", 32'(WriteAddr), 32'd20);
    rst = 1'b0;
    #1;
    chk("midrst_fifo_count", 32'(fifo_count), 32'd0);
    chk("midrst_pending", pending, 32'd0);
    chk("midrst_WriteEn", 32'(WriteEn), 32'd0);
    q.delete();
    pend = 32'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("postrst_mdu_ready", 32'(mdu_ready), 32'd1);
    chk("postrst_fifo_count", 32'(fifo_count), 32'd0);
    tick();

    // Randomized traffic against the queue model; busy then quiet pipeline.
    for (int i = 0; i < 800; i++) begin
      int pct;
      pct = (i < 400) ? 75 : 30;
      pipe_we   = ($urandom_range(0, 99) < pct);
      pipe_addr = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      pipe_data = $urandom;
      mdu_valid = ($urandom_range(0, 1) == 1);
      mdu_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mdu_data  = $urandom;
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_addr  = 5'($urandom_range(0, 31));
      tick();
    end

    setIdle();
    for (int i = 0; i < DEPTH + 2; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter: FIFO_DEPTH, 4, entries in the multi-cycle result buffer (power of two, 2..16).
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on posedge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: pipe_we / pipe_addr / pipe_data  in  1/5/32  in-order writeback request from the pipeline.
REQ-005 SHALL have ports: mdu_valid / mdu_addr / mdu_data  in  1/5/32  multi-cycle unit result offer.
REQ-006 SHALL have port: mdu_ready  out  1  result accepted this cycle when high with mdu_valid.
REQ-007 SHALL have ports: iss_valid / iss_addr  in  1/5  multi-cycle op issued; marks destination pending.
REQ-008 SHALL have ports: WriteEn / WriteAddr / WriteData  out  1/5/32  single register-file write port.
REQ-009 SHALL have port: pending  out  32  bit i high = register i awaits a multi-cycle result.
REQ-010 SHALL have port: fifo_count  out  5  current buffer occupancy.

Function
REQ-011 SHALL drive WriteEn/WriteAddr/WriteData combinationally from the current-cycle winner; no added latency on the pipeline path.
REQ-012 SHALL give the pipeline absolute priority: pipe_we=1 and pipe_addr!=0 -> WriteEn=1, WriteAddr=pipe_addr, WriteData=pipe_data; buffer head held.
REQ-013 SHALL treat pipe_we=1 with pipe_addr=0 as no request; buffer may drain that cycle.
REQ-014 SHALL, with no pipeline request and fifo_count>0, output the buffer head and pop it at the clock edge.
REQ-015 SHALL drive mdu_ready = (fifo_count < FIFO_DEPTH), independent of same-cycle pop (full buffer refuses even if popping).
REQ-016 SHALL push {mdu_addr, mdu_data} on mdu_valid & mdu_ready & mdu_addr!=0; an accepted offer with mdu_addr=0 SHALL be dropped.
REQ-017 SHALL support simultaneous push and pop: count unchanged, order preserved (strict FIFO, pointers wrap modulo FIFO_DEPTH).
REQ-018 SHALL set pending[iss_addr] on iss_valid with iss_addr!=0; pending[0] always 0.
REQ-019 SHALL clear pending[a] at the edge when a buffered/bypassed multi-cycle result for address a is written; pipeline writes never clear pending.
REQ-020 SHALL let set win over clear when both target the same bit in one cycle.
REQ-021 SHALL never drop or duplicate an accepted nonzero-address result.

Reset
REQ-022 SHALL, on rst low, asynchronously clear pointers, fifo_count=0, pending=0; WriteEn=0 unless pipe_we with nonzero address is present.
REQ-023 SHALL discard buffered results on reset mid-operation; mdu_ready=1 after reset release.

Configuration
REQ-024 SHALL honour macro REGWR_BYPASS_EN: when defined, a valid nonzero-address mdu offer with fifo_count=0 and no pipeline request SHALL be written the same cycle (not pushed, mdu_ready=1).
REQ-025 SHALL, without REGWR_BYPASS_EN, always buffer mdu results; earliest write is the cycle after acceptance.

Verification
REQ-026 SHALL cover: reset asserted mid-drain with 3 entries -> fifo_count=0, pending=0 immediately, mdu_ready=1 after release.
REQ-027 SHALL cover: iss_valid addr 5; mdu offers (5, 0xDEADBEEF), idle pipeline -> write R5=0xDEADBEEF (cycle 0 with bypass, cycle 1 without); pending[5] falls after write.
REQ-028 SHALL cover: 4 mdu results while pipe_we=1 every cycle -> fifo_count=4, mdu_ready=0; pipe_we drops -> 4 writes in push order on 4 consecutive cycles.
REQ-029 SHALL cover: full buffer, pipe idle, mdu_valid held -> cycle N pop, mdu_ready still 0; cycle N+1 mdu_ready=1, push accepted.
REQ-030 SHALL cover: iss_valid addr 7 same cycle as buffered write to R7 -> pending[7]=1 afterward; pipe_we addr 0 and mdu addr 0 -> WriteEn never asserted for R0.
